cg_ptw_sv39: RTL and testbench

Sv39 hardware page-table walker that services misses from the fully-associative TLB. It latches the missing virtual address, walks up to three page-table levels rooted at `i_satp_ppn` through a single-outstanding valid/ready memory port, and returns the physical page to the TLB as a one-cycle fill pulse, or raises a page-fault pulse instead. It sits directly downstream of the TLB miss outputs and upstream of the TLB fill inputs.

---
 rtl/cg_mmu_pkg.sv | 55 +++++
 rtl/cg_ptw_sv39_if.sv | 23 ++
 rtl/cg_ptw_pte_check.sv | 71 +++++++
 rtl/cg_ptw_sv39.sv | 132 +++++++++++++
 tb/tb_cg_ptw_sv39.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cg_mmu_pkg.sv
// cg_mmu_pkg
// Shared Sv39 definitions for the page-table walker.
// Contents:
//   - Address and field widths.
//   - The Sv39 PTE layout.
//   - The walker state encoding.
//   - Level constants.
//   - A helper that selects one 9-bit VPN slice from the latched VPN.
package cg_mmu_pkg;

  localparam int VADDR_WIDTH  = 39;
  localparam int PADDR_WIDTH  = 56;
  localparam int PPN_WIDTH    = 44;
  localparam int OFFSET_WIDTH = 12;
  localparam int VPN_WIDTH    = 9;
  localparam int PTE_WIDTH    = 64;
  localparam int LEVELS       = 3;

  typedef logic [1:0] level_t;
  localparam level_t LEVEL_TOP = 2'd2;

  // Sv39 PTE, MSB first: reserved[63:54], ppn[53:10], rsw[9:8], D A G U X W R V
  typedef struct packed {
    logic [9:0]           reserved;
    logic [PPN_WIDTH-1:0] ppn;
    logic [1:0]           rsw;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } pte_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_COOL = 3'd4
  } ptw_state_t;

  // vpn = {vpn2, vpn1, vpn0}
  function automatic logic [VPN_WIDTH-1:0] vpn_at(input logic [3*VPN_WIDTH-1:0] vpn,
                                                  input level_t level);
    case (level)
      2'd2:    vpn_at = vpn[26:18];
      2'd1:    vpn_at = vpn[17:9];
      default: vpn_at = vpn[8:0];
    endcase
  endfunction

endpackage

// File: rtl/cg_ptw_sv39_if.sv
// cg_ptw_sv39_if
// Single-outstanding PTE read port between the walker and memory.
// Signals:
//   req_valid / req_ready  request handshake
//   req_addr               PTE physical address
//   resp_valid / resp_data PTE read response; there is no backpressure
// Modports:
//   master  the walker
//   slave   the memory side
interface cg_ptw_sv39_if;
  import cg_mmu_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [PADDR_WIDTH-1:0] req_addr;
  logic                   resp_valid;
  logic [PTE_WIDTH-1:0]   resp_data;

  modport master (output req_valid, req_addr,
                  input  req_ready, resp_valid, resp_data);
  modport slave  (input  req_valid, req_addr,
                  output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/cg_ptw_pte_check.sv
// cg_ptw_pte_check
// Combinational decode of one Sv39 PTE at a given walk level.
// Macro: when CG_PTW_AD_CHECK_EN is defined, a leaf with A=0, or with W=1 and D=0, faults.
//        When it is undefined, the A and D bits are ignored.
// Inputs:
//   i_pte      PTE under decode
//   i_level    current walk level (2..0)
//   i_vpn_lo   {vpn1, vpn0} of the missing VA
// Outputs:
//   o_leaf      valid leaf
//   o_next      descend one level
//   o_fault     page fault
//   o_leaf_ppn  leaf PPN, with superpage bits filled in from the VA
module cg_ptw_pte_check
  import cg_mmu_pkg::*;
(
  input  pte_t                 i_pte,
  input  level_t               i_level,
  input  logic [17:0]          i_vpn_lo,
  output logic                 o_leaf,
  output logic                 o_next,
  output logic                 o_fault,
  output logic [PPN_WIDTH-1:0] o_leaf_ppn
);

  logic misaligned;
  logic unused_pte_bits;

  assign unused_pte_bits = ^{i_pte.reserved, i_pte.rsw, i_pte.g, i_pte.u, i_pte.a, i_pte.d};

  // A superpage leaf must have zero in the PPN bits the VA supplies.
  always_comb begin
    case (i_level)
      2'd2:    misaligned = |i_pte.ppn[17:0];
      2'd1:    misaligned = |i_pte.ppn[8:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    o_leaf  = 1'b0;
    o_next  = 1'b0;
    o_fault = 1'b0;
    if (!i_pte.v || (!i_pte.r && i_pte.w)) begin
      o_fault = 1'b1;
    end else if (i_pte.r || i_pte.x) begin
      if (misaligned) begin
        o_fault = 1'b1;
`ifdef CG_PTW_AD_CHECK_EN
      end else if (!i_pte.a || (i_pte.w && !i_pte.d)) begin
        o_fault = 1'b1;
`endif
      end else begin
        o_leaf = 1'b1;
      end
    end else if (i_level == 2'd0) begin
      o_fault = 1'b1;
    end else begin
      o_next = 1'b1;
    end
  end

  always_comb begin
    case (i_level)
      2'd2:    o_leaf_ppn = {i_pte.ppn[43:18], i_vpn_lo};
      2'd1:    o_leaf_ppn = {i_pte.ppn[43:9], i_vpn_lo[8:0]};
      default: o_leaf_ppn = i_pte.ppn;
    endcase
  end

endmodule

// File: rtl/cg_ptw_sv39.sv
// cg_ptw_sv39
// Sv39 hardware page-table walker servicing TLB misses.
// Macro: CG_PTW_AD_CHECK_EN (see cg_ptw_pte_check) enables A/D checking on leaves.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_satp_ppn        root page-table PPN
//   i_tlb_miss        miss request; sampled only in IDLE
//   i_tlb_miss_vaddr  missing VA
//   o_ptw_valid       one-cycle fill pulse
//   o_ptw_paddr       {leaf PPN, 12'b0}; held until the next fill
//   o_ptw_fault       one-cycle page-fault pulse
//   o_busy            walk in progress
//   mem               PTE read port (master)
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | waiting for a miss
// REQ   | PTE read request presented, waiting for ready
// WAIT  | request accepted, waiting for the PTE response
// DONE  | one-cycle fill or fault pulse
// COOL  | one cycle ignoring the stale miss after a completed walk
module cg_ptw_sv39
  import cg_mmu_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [PPN_WIDTH-1:0]   i_satp_ppn,
  input  logic                   i_tlb_miss,
  input  logic [VADDR_WIDTH-1:0] i_tlb_miss_vaddr,
  output logic                   o_ptw_valid,
  output logic [PADDR_WIDTH-1:0] o_ptw_paddr,
  output logic                   o_ptw_fault,
  output logic                   o_busy,
  cg_ptw_sv39_if.master          mem
);

  ptw_state_t           state;
  level_t               level;
  logic [PPN_WIDTH-1:0] a_ppn;
  logic [26:0]          vpn_q;
  logic                 req_valid_q;
  pte_t                 pte;
  logic                 pte_leaf;
  logic                 pte_next;
  logic                 pte_fault;
  logic [PPN_WIDTH-1:0] leaf_ppn;
  logic                 unused_vaddr_off;

  assign unused_vaddr_off = ^i_tlb_miss_vaddr[OFFSET_WIDTH-1:0];

  assign pte = pte_t'(mem.resp_data);

  // The address is built only from registers, so it stays stable while REQ waits for ready.
  assign mem.req_valid = req_valid_q;
  assign mem.req_addr  = {a_ppn, vpn_at(vpn_q, level), 3'b000};

  cg_ptw_pte_check u_pte_check (
    .i_pte      (pte),
    .i_level    (level),
    .i_vpn_lo   (vpn_q[17:0]),
    .o_leaf     (pte_leaf),
    .o_next     (pte_next),
    .o_fault    (pte_fault),
    .o_leaf_ppn (leaf_ppn)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      level       <= LEVEL_TOP;
      a_ppn       <= '0;
      vpn_q       <= '0;
      req_valid_q <= 1'b0;
      o_ptw_valid <= 1'b0;
      o_ptw_fault <= 1'b0;
      o_ptw_paddr <= '0;
      o_busy      <= 1'b0;
    end else begin
      o_ptw_valid <= 1'b0;
      o_ptw_fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_tlb_miss) begin
            vpn_q       <= i_tlb_miss_vaddr[VADDR_WIDTH-1:OFFSET_WIDTH];
            level       <= LEVEL_TOP;
            a_ppn       <= i_satp_ppn;
            req_valid_q <= 1'b1;
            o_busy      <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem.req_ready) begin
            req_valid_q <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem.resp_valid) begin
            if (pte_fault) begin
              o_ptw_fault <= 1'b1;
              state       <= ST_DONE;
            end else if (pte_leaf) begin
              o_ptw_valid <= 1'b1;
              o_ptw_paddr <= {leaf_ppn, {OFFSET_WIDTH{1'b0}}};
              state       <= ST_DONE;
            end else if (pte_next) begin
              a_ppn       <= pte.ppn;
              level       <= level - 2'd1;
              req_valid_q <= 1'b1;
              state       <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          state <= ST_COOL;
        end
        ST_COOL: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          req_valid_q <= 1'b0;
          o_busy      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cg_ptw_sv39.sv
// Testbench for cg_ptw_sv39: directed walks with a scoreboard.
// A scoreboard queue holds the expected fill/fault results and the expected PTE request addresses.
// A monitor process pops and checks them whenever the DUT presents them.
module tb_cg_ptw_sv39;
  import cg_mmu_pkg::*;

  logic                   i_clk;
  logic                   i_rst;
  logic [PPN_WIDTH-1:0]   i_satp_ppn;
  logic                   i_tlb_miss;
  logic [VADDR_WIDTH-1:0] i_tlb_miss_vaddr;
  logic                   o_ptw_valid;
  logic [PADDR_WIDTH-1:0] o_ptw_paddr;
  logic                   o_ptw_fault;
  logic                   o_busy;

  cg_ptw_sv39_if mem_if();

  cg_ptw_sv39 dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_satp_ppn       (i_satp_ppn),
    .i_tlb_miss       (i_tlb_miss),
    .i_tlb_miss_vaddr (i_tlb_miss_vaddr),
    .o_ptw_valid      (o_ptw_valid),
    .o_ptw_paddr      (o_ptw_paddr),
    .o_ptw_fault      (o_ptw_fault),
    .o_busy           (o_busy),
    .mem              (mem_if)
  );

  typedef struct {
    bit                     fault;
    logic [PADDR_WIDTH-1:0] pa;
    int                     lat;
  } exp_t;

  exp_t                   exp_q[$];
  logic [PADDR_WIDTH-1:0] addr_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int miss_ref = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks the fill/fault pulses and the request handshakes against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_ptw_valid || o_ptw_fault) begin
        chk("valid_and_fault", {62'd0, o_ptw_valid, o_ptw_fault} == 64'd3, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {62'd0, o_ptw_valid, o_ptw_fault}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {62'd0, o_ptw_valid, o_ptw_fault}, e.fault ? 64'd1 : 64'd2);
          if (!e.fault) chk("fill_paddr", 64'(o_ptw_paddr), 64'(e.pa));
          if (e.lat != 0) chk("done_cycle", 64'(cyc - miss_ref), 64'(e.lat));
        end
      end
      if (mem_if.req_valid && mem_if.req_ready) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_req", 64'(mem_if.req_addr), 64'd0);
        end else begin
          chk("req_addr", 64'(mem_if.req_addr), 64'(addr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_walk(input logic [VADDR_WIDTH-1:0] va, input logic [PPN_WIDTH-1:0] root,
                          input int n, input logic [63:0] p0, input logic [63:0] p1,
                          input logic [63:0] p2, input int rdly, input int sdly, input bit hold,
                          input bit efault, input logic [PADDR_WIDTH-1:0] epa, input int lat,
                          input logic [PADDR_WIDTH-1:0] a0, input logic [PADDR_WIDTH-1:0] a1,
                          input logic [PADDR_WIDTH-1:0] a2);
    logic [63:0]            ptes[3];
    logic [PADDR_WIDTH-1:0] addrs[3];
    exp_t e;
    int cnt;
    ptes[0] = p0; ptes[1] = p1; ptes[2] = p2;
    addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
    e.fault = efault; e.pa = epa; e.lat = lat;
    exp_q.push_back(e);
    for (int k = 0; k < n; k++) addr_q.push_back(addrs[k]);

    i_tlb_miss_vaddr = va;
    i_satp_ppn       = root;
    i_tlb_miss       = 1'b1;
    @(posedge i_clk); #1;
    miss_ref = cyc - 1;
    if (!hold) i_tlb_miss = 1'b0;

    for (int k = 0; k < n; k++) begin
      cnt = 0;
      while (!mem_if.req_valid && cnt < 50) begin
        @(posedge i_clk); #1;
        cnt++;
      end
      if (!mem_if.req_valid) begin
        chk("req_timeout", 64'd0, 64'd1);
        exp_q.delete();
        addr_q.delete();
        i_tlb_miss = 1'b0;
        return;
      end
      for (int d = 0; d < rdly; d++) begin
        chk("req_addr_stable", 64'(mem_if.req_addr), 64'(addrs[k]));
        @(posedge i_clk); #1;
      end
      mem_if.req_ready = 1'b1;
      @(posedge i_clk); #1;
      mem_if.req_ready = 1'b0;
      for (int d = 0; d < sdly; d++) begin
        @(posedge i_clk); #1;
      end
      mem_if.resp_valid = 1'b1;
      mem_if.resp_data  = ptes[k];
      @(posedge i_clk); #1;
      mem_if.resp_valid = 1'b0;
    end

    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
    chk("req_count", 64'(addr_q.size()), 64'd0);
    addr_q.delete();
    // Now in COOL; a held miss must still be ignored here.
    @(posedge i_clk); #1;
    i_tlb_miss = 1'b0;
    if (!efault) chk("paddr_held", 64'(o_ptw_paddr), 64'(epa));
    if (hold) begin
      for (int d = 0; d < 3; d++) begin
        chk("no_second_walk", {62'd0, o_busy, mem_if.req_valid}, 64'd0);
        @(posedge i_clk); #1;
      end
    end
  endtask

  initial begin
    i_rst = 1'b1;
    i_tlb_miss = 1'b0;
    i_tlb_miss_vaddr = '0;
    i_satp_ppn = '0;
    mem_if.req_ready = 1'b0;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_data = '0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    chk("reset_outputs", {60'd0, o_ptw_valid, o_ptw_fault, o_busy, mem_if.req_valid}, 64'd0);
    chk("reset_paddr", 64'(o_ptw_paddr), 64'd0);

    // Full three-level walk, zero-wait memory.
    run_walk(39'h00_4000_1234, 44'h100, 3, 64'h80001, 64'hC0001, 64'h2AF378CF, 0, 0, 0,
             0, 56'hABCDE000, 7, 56'h100008, 56'h200000, 56'h300008);
    // Level-1 superpage leaf: vpn0 fills ppn[8:0].
    run_walk(39'h00_4045_5ABC, 44'h100, 2, 64'h80001, 64'h100800CF, 64'h0, 0, 0, 0,
             0, 56'h40255000, 5, 56'h100008, 56'h200010, 56'h0);
    // Level-1 leaf with ppn[8:0] nonzero: misaligned.
    run_walk(39'h00_4045_5ABC, 44'h100, 2, 64'h80001, 64'h100804CF, 64'h0, 0, 0, 0,
             1, 56'h0, 5, 56'h100008, 56'h200010, 56'h0);
    // L2 PTE with V=0.
    run_walk(39'h00_4000_1234, 44'h100, 1, 64'h0, 64'h0, 64'h0, 0, 0, 0,
             1, 56'h0, 3, 56'h100008, 56'h0, 56'h0);
    // W=1 with R=0.
    run_walk(39'h00_4000_1234, 44'h100, 1, 64'h5, 64'h0, 64'h0, 0, 0, 0,
             1, 56'h0, 3, 56'h100008, 56'h0, 56'h0);
    // Non-leaf at level 0.
    run_walk(39'h00_4000_1234, 44'h100, 3, 64'h80001, 64'hC0001, 64'h40001, 0, 0, 0,
             1, 56'h0, 7, 56'h100008, 56'h200000, 56'h300008);
    // Level-2 superpage leaf.
    run_walk(39'h00_4045_5ABC, 44'h100, 1, 64'h100000CF, 64'h0, 64'h0, 0, 0, 0,
             0, 56'h40455000, 3, 56'h100008, 56'h0, 56'h0);
    // Level-2 leaf with ppn[17:0] nonzero: misaligned.
    run_walk(39'h00_4045_5ABC, 44'h100, 1, 64'h100800CF, 64'h0, 64'h0, 0, 0, 0,
             1, 56'h0, 3, 56'h100008, 56'h0, 56'h0);
    // Slow memory with the miss held high through the walk and COOL.
    run_walk(39'h00_4000_1234, 44'h100, 3, 64'h80001, 64'hC0001, 64'h2AF378CF, 5, 4, 1,
             0, 56'hABCDE000, 0, 56'h100008, 56'h200000, 56'h300008);
    // Leaf with A=0.
`ifdef CG_PTW_AD_CHECK_EN
    run_walk(39'h00_4045_5ABC, 44'h100, 1, 64'h1000000F, 64'h0, 64'h0, 0, 0, 0,
             1, 56'h0, 3, 56'h100008, 56'h0, 56'h0);
`else
    run_walk(39'h00_4045_5ABC, 44'h100, 1, 64'h1000000F, 64'h0, 64'h0, 0, 0, 0,
             0, 56'h40455000, 3, 56'h100008, 56'h0, 56'h0);
`endif

    // Reset while in WAIT, then a late response.
    addr_q.push_back(56'h100008);
    i_tlb_miss_vaddr = 39'h00_4000_1234;
    i_satp_ppn = 44'h100;
    i_tlb_miss = 1'b1;
    @(posedge i_clk); #1;
    i_tlb_miss = 1'b0;
    chk("rst_walk_addr", 64'(mem_if.req_addr), 64'h100008);
    mem_if.req_ready = 1'b1;
    @(posedge i_clk); #1;
    mem_if.req_ready = 1'b0;
    chk("rst_walk_busy", {63'd0, o_busy}, 64'd1);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    mem_if.resp_valid = 1'b1;
    mem_if.resp_data = 64'h100000CF;
    @(posedge i_clk); #1;
    mem_if.resp_valid = 1'b0;
    chk("rst_outputs", {60'd0, o_ptw_valid, o_ptw_fault, o_busy, mem_if.req_valid}, 64'd0);
    chk("rst_req_addr", 64'(mem_if.req_addr), 64'd0);
    chk("rst_paddr", 64'(o_ptw_paddr), 64'd0);
    repeat (4) @(posedge i_clk);
    #1;
    chk("rst_stays_idle", {63'd0, o_busy}, 64'd0);
    chk("rst_req_count", 64'(addr_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
